// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_uart_tx_if : data-memory bus signals snooped by the MMIO UART       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface mmio_uart_tx_if;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [2:0]  funct3;
  logic [31:0] dmem_data_out;
  logic        periph_sel;

  modport master (
    output dmem_wren,
    output dmem_address,
    output dmem_data_in,
    output funct3,
    input  dmem_data_out,
    input  periph_sel
  );

  modport slave (
    input  dmem_wren,
    input  dmem_address,
    input  dmem_data_in,
    input  funct3,
    output dmem_data_out,
    output periph_sel
  );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_uart_tx : store-snooping byte FIFO feeding an 8N1 UART transmitter  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFE0,
  parameter int          CLK_FREQ   = 12000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_BAUD_W       = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
  localparam int c_PTR_W        = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W        = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]         c_STAT_ADDR = BASE_ADDR + 32'd4;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic                w_hit_data;
  logic                w_hit_stat;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_clr_ovf;
  logic                w_baud_done;
  logic [31:0]         w_status;
  logic                w_unused;

  logic [1:0]          state_q, state_d;
  logic [c_BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  wr_ptr_q;
  logic [c_PTR_W-1:0]  rd_ptr_q;
  logic [c_CNT_W-1:0]  count_q;
  logic                ovf_q;

  logic                sel_q;
  logic [31:0]         rdata_q;

  assign w_hit_data  = (bus.dmem_address == BASE_ADDR);
  assign w_hit_stat  = (bus.dmem_address == c_STAT_ADDR);
  assign w_push_req  = bus.dmem_wren && w_hit_data;
  assign w_pop       = (state_q == c_IDLE) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push      = w_push_req && ((count_q < c_DEPTH) || w_pop);
  assign w_clr_ovf   = bus.dmem_wren && w_hit_stat && bus.dmem_data_in[3];
  assign w_baud_done = (baud_q == c_BAUD_LAST);

  assign w_status = {23'd0, 5'(count_q), ovf_q, (state_q != c_IDLE),
                     (count_q == '0), (count_q == c_DEPTH)};

  // Only the low byte is stored; access size and upper data bits are don't-care.
  assign w_unused = ^{bus.funct3, bus.dmem_data_in[31:8]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.dmem_data_in[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_push_req && !w_push) begin
        ovf_q <= 1'b1;
      end else if (w_clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      c_IDLE: begin
        if (w_pop) begin
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = c_START;
        end
      end
      c_START: begin
        if (w_baud_done) begin
          baud_d  = '0;
          state_d = c_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      c_DATA: begin
        if (w_baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = c_STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      c_STOP: begin
        if (w_baud_done) begin
          baud_d  = '0;
          state_d = c_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Line level is derived from the next state so tx falls one cycle after the pop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      c_START: tx_d = 1'b0;
      c_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q    <= 1'b1;
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      tx_q    <= tx_d;
      sel_q   <= w_hit_stat | w_hit_data;
      rdata_q <= w_hit_stat ? w_status : 32'd0;
    end
  end

  assign tx                = tx_q;
  assign bus.dmem_data_out = rdata_q;
  assign bus.periph_sel    = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mmio_uart_tx : scoreboard bench for read responses and UART frames    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_FFE0;
  localparam logic [31:0] STAT  = 32'hFFFF_FFE4;
  localparam int          CPB   = 104;
  localparam int          FRAME = 10 * CPB + 1;

  typedef struct { int unsigned cyc;  logic [31:0] data; } rd_exp_t;
  typedef struct { int unsigned fall; logic [7:0]  data; } tx_exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        tx;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  rd_exp_t rd_q[$];
  tx_exp_t tx_exp_q[$];

  mmio_uart_tx_if bif ();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_FREQ   (12000000),
    .BAUD       (115200),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) tick();
  endtask

  task automatic bus_cycle(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_rd);
    bif.dmem_wren    = wr;
    bif.dmem_address = addr;
    bif.dmem_data_in = data;
    bif.funct3       = 3'b010;
    if (addr == BASE || addr == STAT) rd_q.push_back('{cyc + 1, exp_rd});
    tick();
    bif.dmem_wren    = 1'b0;
    bif.dmem_address = 32'h0;
    bif.dmem_data_in = 32'h0;
  endtask

  task automatic rd_stat(input logic [31:0] exp);
    bus_cycle(1'b0, STAT, 32'h0, exp);
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit sent, input int unsigned fall);
    if (sent) tx_exp_q.push_back('{fall, b});
    bus_cycle(1'b1, BASE, {24'h0, b}, 32'h0);
  endtask

  // Read-path monitor
  always @(negedge clk) begin
    rd_exp_t e;
    if (reset) begin
      if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        e = rd_q.pop_front();
        check("rd_periph_sel", bif.periph_sel, 32'd1);
        check("rd_data", bif.dmem_data_out, e.data);
      end else if (bif.periph_sel) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: periph_sel=1 data 0x%0h, required no response (cycle %0d)",
                 bif.dmem_data_out, cyc);
      end
    end
  end

  // UART receiver monitor
  int      rx_k    = 0;
  bit      rx_act  = 1'b0;
  bit      rx_have = 1'b0;
  logic [7:0] rx_byte;
  tx_exp_t rx_e;

  always @(negedge clk) begin
    int b;
    if (!reset) begin
      rx_act = 1'b0;
    end else begin
      if (!rx_act && tx == 1'b0) begin
        rx_act  = 1'b1;
        rx_k    = 0;
        rx_byte = 8'h0;
        rx_have = (tx_exp_q.size() > 0);
        if (rx_have) begin
          rx_e = tx_exp_q.pop_front();
          check("frame_start_cycle", cyc, rx_e.fall);
        end else begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: start bit at cycle %0d, required none", cyc);
        end
      end else if (rx_act) begin
        rx_k++;
      end
      if (rx_act) begin
        if (rx_k == CPB - 1) check("start_last_cycle", tx, 32'd0);
        if ((rx_k % CPB) == CPB / 2) begin
          b = rx_k / CPB;
          if (b == 0)      check("start_bit", tx, 32'd0);
          else if (b <= 8) rx_byte[b-1] = tx;
          else             check("stop_bit", tx, 32'd1);
        end
        if (rx_k == 10 * CPB - 1) begin
          check("stop_last_cycle", tx, 32'd1);
          if (rx_have) check("frame_byte", {24'h0, rx_byte}, {24'h0, rx_e.data});
          rx_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    bif.dmem_wren    = 1'b0;
    bif.dmem_address = 32'h0;
    bif.dmem_data_in = 32'h0;
    bif.funct3       = 3'b000;

    repeat (3) tick();
    check("reset_tx", tx, 32'd1);
    check("reset_periph_sel", bif.periph_sel, 32'd0);
    check("reset_data_out", bif.dmem_data_out, 32'd0);
    reset = 1'b1;

    // Idle line and empty status
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_tx", tx, 32'd1);
    end
    rd_stat(32'h0000_0002);

    // Single byte 0xA5
    repeat (5) tick();
    c = cyc;
    wr_byte(8'hA5, 1'b1, c + 2);
    wait_until(c + 500);
    rd_stat(32'h0000_0006);
    wait_until(c + 1041);
    rd_stat(32'h0000_0006);
    rd_stat(32'h0000_0002);

    // Two bytes back-to-back, one idle cycle apart
    repeat (10) tick();
    c = cyc;
    wr_byte(8'h55, 1'b1, c + 2);
    wr_byte(8'h0F, 1'b1, c + 2 + FRAME);
    wait_until(c + 600);
    rd_stat(32'h0000_0014);
    wait_until(c + 2 + 2 * FRAME + 10);

    // Overflow: first byte popped, eight buffered, tenth dropped
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      wr_byte(8'h30 + 8'(i), (i < 9), c + 2 + int'(i) * FRAME);
    end
    rd_stat(32'h0000_008D);
    bus_cycle(1'b1, STAT, 32'h0000_0008, 32'h0000_008D);
    rd_stat(32'h0000_0085);

    // Push into a full FIFO in the idle cycle that pops it
    wait_until(c + 1042);
    wr_byte(8'hE7, 1'b1, c + 2 + 9 * FRAME);
    rd_stat(32'h0000_0085);
    wait_until(c + 2 + 10 * FRAME + 10);
    check("frames_drained", tx_exp_q.size(), 32'd0);

    // Reset in the middle of the data bits
    c = cyc;
    wr_byte(8'h00, 1'b1, c + 2);
    wait_until(c + 522);
    check("mid_data_tx", tx, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_tx", tx, 32'd1);
    check("async_reset_sel", bif.periph_sel, 32'd0);
    check("async_reset_data", bif.dmem_data_out, 32'd0);
    tx_exp_q.delete();
    rd_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    rd_stat(32'h0000_0002);
    for (int i = 0; i < 12; i++) begin
      repeat (100) tick();
      check("post_reset_idle_tx", tx, 32'd1);
    end
    rd_stat(32'h0000_0002);
    repeat (3) tick();
    check("rd_queue_empty", rd_q.size(), 32'd0);
    check("tx_queue_empty", tx_exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
